gmii_rx_frame_ctrl: RTL and testbench
=====================================

// Module: gmii_rx_frame_ctrl
// PURPOSE
//  Frame-delineation controller for the GMII RX stream produced by the RGMII RX converter.
//  Strips preamble/SFD, emits frame bytes with sof/eof framing and a final error flag,
//  measures frame length, enforces min/max length and keeps good/bad frame counters.
//  Sits between the RGMII->GMII converter and the MAC RX buffer, in the GMII RX clock domain.
// PARAMETERS
//  MIN_LEN  64    minimum legal frame length in bytes, post-SFD incl. FCS
//  MAX_LEN  1518  maximum legal frame length in bytes (must be <= 4095)
// PORTS
//  GMII_RX_CLK_i   in   1   GMII RX clock; the only clock in this block
//  reset_n         in   1   asynchronous, active-low reset
//  gmii_rxd_i      in   8   GMII RX data
//  gmii_rx_dv_i    in   1   GMII RX data valid
//  gmii_rx_er_i    in   1   GMII RX error
//  enable_i        in   1   accept new frames; sampled only in IDLE
//  frm_data_o      out  8   frame byte (first byte after SFD .. last FCS byte)
//  frm_valid_o     out  1   frm_data_o valid this cycle
//  frm_sof_o       out  1   first byte of frame, qualified by frm_valid_o
//  frm_eof_o       out  1   last byte of frame, qualified by frm_valid_o
//  frm_err_o       out  1   frame bad; meaningful only with frm_eof_o
//  frm_len_o       out  12  frame byte count; updated on the eof cycle, held until the next eof
//  good_cnt_o      out  16  frames ended with err=0; saturates at 16'hFFFF
//  bad_cnt_o       out  16  frames ended with err=1, plus zero-length frames; saturates
//  busy_o          out  1   state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, armed=0, holding buffer empty.
//  - armed flag:
//      - set on the first cycle with dv=0 after reset.
//      - IDLE ignores dv until armed, so no partial frame is accepted after reset.
//  - FSM states IDLE, PRE, DATA, DROP:
//      - IDLE, dv=1, armed, enable_i=1: rxd=55 -> PRE; rxd=D5 -> DATA; else -> DROP.
//        If enable_i=0 or not armed: stay in IDLE, no output, counters unchanged.
//      - PRE: dv=0 -> IDLE (no count); er=1 -> DROP; 55 -> PRE; D5 -> DATA; other -> DROP.
//      - DATA: each dv=1 byte is written into a 1-byte holding buffer.
//          - When the buffer is already full, its previous byte is emitted.
//          - dv=0 -> buffered byte emitted with eof=1 -> IDLE.
//          - dv=0 with the buffer empty (SFD then dv low): no output, bad_cnt+1 -> IDLE.
//      - DROP: wait for dv=0 -> IDLE; no output, no count.
//  - Latency: a byte sampled on edge t appears on frm_data_o after edge t+1.
//    Output pulses are single-cycle registered outputs; there is no backpressure.
//  - sof is set on the first emitted byte of a frame.
//    A 1-byte frame carries sof=eof=1 and err=1 (runt).
//  - Length counter:
//      - 12 bits, counts bytes accepted in DATA.
//      - If a byte arrives while len==MAX_LEN, the buffered byte is emitted with eof=1, err=1,
//        frm_len_o=MAX_LEN, and the FSM goes to DROP. The incoming byte is discarded.
//  - err is the OR of:
//      - er sampled high during DATA (including the last byte),
//      - len < MIN_LEN at eof,
//      - MAX_LEN truncation.
//  - Counters: good_cnt or bad_cnt increments on the eof cycle; both saturate.
//  - enable_i going low mid-frame has no effect; the current frame completes normally.
//  - reset_n asserted mid-frame: outputs clear immediately (async).
//    No eof is emitted for the aborted frame. armed=0 until dv is seen low.
// TESTING
//  1. 7x55, D5, 64 bytes 00..3F, dv low
//       -> 64 valid pulses; sof on 00, eof on 3F; err=0, len=64, good_cnt=1.
//  2. Preamble + 60-byte frame
//       -> eof on byte 60 with err=1, len=60, bad_cnt=1, good_cnt unchanged.
//  3. 100-byte frame, er high on byte 10 only
//       -> all 100 bytes emitted; eof err=1, len=100, bad_cnt+1.
//  4. 1600-byte frame with MAX_LEN=1518
//       -> eof on byte 1518, err=1, len=1518, no valid for bytes 1519+.
//       -> A following 64-byte frame ends with err=0.
//  5. reset_n low during byte 30, released with dv still high
//       -> outputs 0 at once, no output for the rest of that frame; next full frame is good.
//  6. enable_i=0, send frame
//       -> no valid, counters unchanged.
//     enable_i dropped at byte 5 of an accepted frame
//       -> frame completes, good_cnt+1.

Source files
------------

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII RX frame delineation: strips preamble/SFD, frames bytes with sof/eof/err,
// measures length, enforces min/max length and keeps good/bad frame counters.
module gmii_rx_frame_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        GMII_RX_CLK_i,
  input  logic        reset_n,
  input  logic [7:0]  gmii_rxd_i,
  input  logic        gmii_rx_dv_i,
  input  logic        gmii_rx_er_i,
  input  logic        enable_i,
  output logic [7:0]  frm_data_o,
  output logic        frm_valid_o,
  output logic        frm_sof_o,
  output logic        frm_eof_o,
  output logic        frm_err_o,
  output logic [11:0] frm_len_o,
  output logic [15:0] good_cnt_o,
  output logic [15:0] bad_cnt_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [7:0]  PREAMBLE = 8'h55;
  localparam logic [7:0]  SFD      = 8'hD5;
  localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L    = 12'(MAX_LEN);

  state_t      state, state_nx;
  logic        armed;
  logic [7:0]  hold;       // one-byte holding buffer so the last byte can carry eof
  logic        hold_full;
  logic        acc_err;    // er seen on any accepted byte of this frame
  logic [11:0] len;
  logic        first;      // next emitted byte is the sof byte

  logic        emit, emit_eof, emit_err, take, zero_len;

  // Next-state and per-cycle emit decisions
  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    emit_eof = 1'b0;
    emit_err = 1'b0;
    take     = 1'b0;
    zero_len = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv_i && armed && enable_i) begin
          if (gmii_rxd_i == PREAMBLE)  state_nx = PRE;
          else if (gmii_rxd_i == SFD)  state_nx = DATA;
          else                         state_nx = DROP;
        end
      end
      PRE: begin
        if (!gmii_rx_dv_i)                state_nx = IDLE;
        else if (gmii_rx_er_i)            state_nx = DROP;
        else if (gmii_rxd_i == PREAMBLE)  state_nx = PRE;
        else if (gmii_rxd_i == SFD)       state_nx = DATA;
        else                              state_nx = DROP;
      end
      DATA: begin
        if (!gmii_rx_dv_i) begin
          state_nx = IDLE;
          if (hold_full) begin
            emit     = 1'b1;
            emit_eof = 1'b1;
            emit_err = acc_err || (len < MIN_L);
          end else begin
            zero_len = 1'b1;
          end
        end else if (len == MAX_L) begin
          // Truncate: close the frame on the buffered byte, discard the rest
          state_nx = DROP;
          emit     = 1'b1;
          emit_eof = 1'b1;
          emit_err = 1'b1;
        end else begin
          emit = hold_full;
          take = 1'b1;
        end
      end
      DROP: begin
        if (!gmii_rx_dv_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, arming, holding buffer and length
  always_ff @(posedge GMII_RX_CLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      acc_err   <= 1'b0;
      len       <= 12'd0;
      first     <= 1'b1;
    end else begin
      state <= state_nx;
      if (!gmii_rx_dv_i) armed <= 1'b1;
      if (state != DATA) begin
        hold_full <= 1'b0;
        acc_err   <= 1'b0;
        len       <= 12'd0;
        first     <= 1'b1;
      end else begin
        if (emit) first <= 1'b0;
        if (take) begin
          hold      <= gmii_rxd_i;
          hold_full <= 1'b1;
          acc_err   <= acc_err | gmii_rx_er_i;
          len       <= len + 12'd1;
        end
      end
    end
  end

  // Registered frame outputs, length capture and saturating counters
  always_ff @(posedge GMII_RX_CLK_i or negedge reset_n) begin
    if (!reset_n) begin
      frm_data_o  <= 8'h00;
      frm_valid_o <= 1'b0;
      frm_sof_o   <= 1'b0;
      frm_eof_o   <= 1'b0;
      frm_err_o   <= 1'b0;
      frm_len_o   <= 12'd0;
      good_cnt_o  <= 16'd0;
      bad_cnt_o   <= 16'd0;
    end else begin
      frm_valid_o <= emit;
      frm_data_o  <= emit ? hold : 8'h00;
      frm_sof_o   <= emit & first;
      frm_eof_o   <= emit_eof;
      frm_err_o   <= emit_eof & emit_err;
      if (emit_eof) frm_len_o <= len;
      if ((emit_eof && !emit_err) && good_cnt_o != 16'hFFFF)
        good_cnt_o <= good_cnt_o + 16'd1;
      if (((emit_eof && emit_err) || zero_len) && bad_cnt_o != 16'hFFFF)
        bad_cnt_o <= bad_cnt_o + 16'd1;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed bench for gmii_rx_frame_ctrl: frames driven on negedge, outputs
// collected by a monitor just after each posedge and compared against hand values.
module tb_gmii_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  frm_data;
  logic        frm_valid, frm_sof, frm_eof, frm_err, busy;
  logic [11:0] frm_len;
  logic [15:0] good_cnt, bad_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // monitor state
  int         n_valid, n_sof, n_eof, seq_err, exp_byte;
  logic [7:0] sof_data, eof_data;
  logic       eof_err;

  gmii_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .GMII_RX_CLK_i (clk),
    .reset_n       (rst_n),
    .gmii_rxd_i    (rxd),
    .gmii_rx_dv_i  (dv),
    .gmii_rx_er_i  (er),
    .enable_i      (en),
    .frm_data_o    (frm_data),
    .frm_valid_o   (frm_valid),
    .frm_sof_o     (frm_sof),
    .frm_eof_o     (frm_eof),
    .frm_err_o     (frm_err),
    .frm_len_o     (frm_len),
    .good_cnt_o    (good_cnt),
    .bad_cnt_o     (bad_cnt),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mon_clear();
    n_valid = 0; n_sof = 0; n_eof = 0; seq_err = 0; exp_byte = 0;
    sof_data = 8'h00; eof_data = 8'h00; eof_err = 1'b0;
  endtask

  // Collect emitted bytes; frame payload is expected to be 00,01,02,... mod 256
  always @(posedge clk) begin
    #1;
    if (frm_valid) begin
      if (frm_data !== 8'(exp_byte)) seq_err++;
      exp_byte++;
      n_valid++;
      if (frm_sof) begin n_sof++; sof_data = frm_data; end
      if (frm_eof) begin n_eof++; eof_data = frm_data; eof_err = frm_err; end
    end
  end

  // npre x 55, D5, nbytes of payload i[7:0]; er on payload index er_at;
  // enable dropped on payload index en_off_at; then 5 idle cycles.
  task automatic send_frame(input int npre, input int nbytes, input int er_at, input int en_off_at);
    for (int i = 0; i < npre; i++) begin
      @(negedge clk); dv = 1'b1; rxd = 8'h55; er = 1'b0;
    end
    @(negedge clk); dv = 1'b1; rxd = 8'hD5; er = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk); rxd = 8'(i); er = (i == er_at);
      if (i == en_off_at) en = 1'b0;
    end
    @(negedge clk); dv = 1'b0; er = 1'b0; rxd = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    mon_clear();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(frm_valid), 0);
    chk("rst_good",  32'(good_cnt), 0);
    chk("rst_bad",   32'(bad_cnt), 0);
    chk("rst_len",   32'(frm_len), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: good 64-byte frame
    mon_clear();
    send_frame(7, 64, -1, -1);
    chk("t1_nvalid", n_valid, 64);
    chk("t1_nsof",   n_sof, 1);
    chk("t1_sofd",   32'(sof_data), 32'h00);
    chk("t1_neof",   n_eof, 1);
    chk("t1_eofd",   32'(eof_data), 32'h3F);
    chk("t1_err",    32'(eof_err), 0);
    chk("t1_seq",    seq_err, 0);
    chk("t1_len",    32'(frm_len), 64);
    chk("t1_good",   32'(good_cnt), 1);
    chk("t1_bad",    32'(bad_cnt), 0);
    chk("t1_busy",   32'(busy), 0);

    // 2: runt 60-byte frame
    mon_clear();
    send_frame(7, 60, -1, -1);
    chk("t2_nvalid", n_valid, 60);
    chk("t2_eofd",   32'(eof_data), 32'h3B);
    chk("t2_err",    32'(eof_err), 1);
    chk("t2_len",    32'(frm_len), 60);
    chk("t2_good",   32'(good_cnt), 1);
    chk("t2_bad",    32'(bad_cnt), 1);

    // 3: 100-byte frame with er on byte 10
    mon_clear();
    send_frame(7, 100, 9, -1);
    chk("t3_nvalid", n_valid, 100);
    chk("t3_seq",    seq_err, 0);
    chk("t3_err",    32'(eof_err), 1);
    chk("t3_len",    32'(frm_len), 100);
    chk("t3_bad",    32'(bad_cnt), 2);
    chk("t3_good",   32'(good_cnt), 1);

    // 4: oversize frame truncated at MAX_LEN, then a good frame
    mon_clear();
    send_frame(7, 1600, -1, -1);
    chk("t4_nvalid", n_valid, 1518);
    chk("t4_neof",   n_eof, 1);
    chk("t4_eofd",   32'(eof_data), 32'hED);
    chk("t4_err",    32'(eof_err), 1);
    chk("t4_len",    32'(frm_len), 1518);
    chk("t4_bad",    32'(bad_cnt), 3);
    mon_clear();
    send_frame(7, 64, -1, -1);
    chk("t4b_err",   32'(eof_err), 0);
    chk("t4b_neof",  n_eof, 1);
    chk("t4b_good",  32'(good_cnt), 2);
    chk("t4b_len",   32'(frm_len), 64);

    // 5: reset during byte 30, released with dv high
    mon_clear();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); dv = 1'b1; rxd = 8'h55;
    end
    @(negedge clk); rxd = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); rxd = 8'(i);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(frm_valid), 0);
    chk("t5_busy",  32'(busy), 0);
    chk("t5_good",  32'(good_cnt), 0);
    chk("t5_bad",   32'(bad_cnt), 0);
    chk("t5_len",   32'(frm_len), 0);
    mon_clear();
    for (int i = 30; i < 64; i++) begin
      @(negedge clk); rst_n = 1'b1; rxd = 8'(i);
    end
    @(negedge clk); dv = 1'b0; rxd = 8'h00;
    repeat (4) @(negedge clk);
    chk("t5_nvalid", n_valid, 0);
    chk("t5_neof",   n_eof, 0);
    chk("t5_bad2",   32'(bad_cnt), 0);
    mon_clear();
    send_frame(7, 64, -1, -1);
    chk("t5b_nvalid", n_valid, 64);
    chk("t5b_err",    32'(eof_err), 0);
    chk("t5b_good",   32'(good_cnt), 1);

    // 6: disabled, then enable dropped mid-frame
    mon_clear();
    en = 1'b0;
    send_frame(7, 64, -1, -1);
    chk("t6_nvalid", n_valid, 0);
    chk("t6_good",   32'(good_cnt), 1);
    chk("t6_bad",    32'(bad_cnt), 0);
    en = 1'b1;
    mon_clear();
    send_frame(7, 64, -1, 4);
    chk("t6b_nvalid", n_valid, 64);
    chk("t6b_err",    32'(eof_err), 0);
    chk("t6b_good",   32'(good_cnt), 2);
    en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
